// File: rtl/ds2431_read_streamer_pkg.sv
// rtl/ds2431_read_streamer_pkg.sv - shared types and constants for the DS2431 read streamer
package ds2431_read_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_REL  = 3'd4
    } rd_state_t;

    localparam logic [7:0] CMD_READ_MEMORY   = 8'hF0;
    localparam logic [7:0] LAST_ADDR_DEFAULT = 8'h8F;

endpackage

// File: rtl/ds2431_read_streamer_ow_dq_sync.sv
// rtl/ds2431_read_streamer_ow_dq_sync.sv - 1-Wire DQ synchroniser with falling-edge detect
//  i_clk, i_nRst : clock, asynchronous active-low reset
//  i_dq_in       : raw asynchronous line level
//  o_dq_s        : synchronised line level
//  o_fall        : 1 while the synchronised level has just gone 1 -> 0
module ow_dq_sync
    import ds2431_read_streamer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_nRst,
    input  logic i_dq_in,
    output logic o_dq_s,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Idle 1-Wire line is high, so reset to 1s to avoid a false fall.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_dq_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_dq_s = r_sync[SYNC_STAGES-1];
    assign o_fall = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ds2431_read_streamer.sv
// rtl/ds2431_read_streamer.sv - READ MEMORY data phase: streams bytes LSB-first in master read slots
//  i_clk, i_nRst       : clock, asynchronous active-low reset
//  i_start, i_ta1/ta2  : begin streaming from {ta2,ta1}
//  i_abort             : stop the session immediately (wins over start)
//  i_dq_in / o_dq_pull : raw line level / open-drain pull-low enable
//  o_mem_addr/i_row_dat: row select and combinational 64-bit row data
//  o_busy, o_byte_done, o_cur_addr : session status
module ds2431_read_streamer
    import ds2431_read_streamer_pkg::*;
#(
    parameter int         HOLD_CYC    = 30,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] LAST_ADDR   = LAST_ADDR_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_nRst,
    input  logic        i_start,
    input  logic [7:0]  i_ta1,
    input  logic [7:0]  i_ta2,
    input  logic        i_abort,
    input  logic        i_dq_in,
    output logic        o_dq_pull,
    output logic [7:0]  o_mem_addr,
    input  logic [63:0] i_row_dat,
    output logic        o_busy,
    output logic        o_byte_done,
    output logic [15:0] o_cur_addr
);

    localparam int             TW        = $clog2(HOLD_CYC + 1);
    localparam logic [TW-1:0]  HOLD_LOAD = TW'(HOLD_CYC);

    rd_state_t     r_state,     w_state;
    logic [15:0]   r_cur_addr,  w_cur_addr;
    logic [7:0]    r_shreg,     w_shreg;
    logic [2:0]    r_bitcnt,    w_bitcnt;
    logic [TW-1:0] r_timer,     w_timer;
    logic          r_dq_pull,   w_dq_pull;
    logic          r_busy,      w_busy;
    logic          r_byte_done, w_byte_done;

    logic          w_dq_s;
    logic          w_fall;
    logic [7:0]    w_row_byte;
    logic          w_in_range;

    ow_dq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (i_clk),
        .i_nRst  (i_nRst),
        .i_dq_in (i_dq_in),
        .o_dq_s  (w_dq_s),
        .o_fall  (w_fall)
    );

    // Row select always follows the current address, so row_dat is already
    // valid for the byte being loaded; row crossings need no special case.
    assign o_mem_addr = r_cur_addr[7:0];
    assign w_row_byte = i_row_dat[{r_cur_addr[2:0], 3'b000} +: 8];
    // Full 16-bit compare: any non-zero high byte is out of range.
    assign w_in_range = (r_cur_addr <= {8'h00, LAST_ADDR});

    always_comb begin
        w_state     = r_state;
        w_cur_addr  = r_cur_addr;
        w_shreg     = r_shreg;
        w_bitcnt    = r_bitcnt;
        w_timer     = r_timer;
        w_dq_pull   = r_dq_pull;
        w_busy      = r_busy;
        w_byte_done = 1'b0;
        if (i_abort) begin
            w_state   = ST_IDLE;
            w_dq_pull = 1'b0;
            w_busy    = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_cur_addr = {i_ta2, i_ta1};
                        w_busy     = 1'b1;
                        w_state    = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    w_shreg  = w_in_range ? w_row_byte : 8'hFF;
                    w_bitcnt = 3'd0;
                    w_state  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_fall) begin
                        w_dq_pull = ~r_shreg[0];
                        w_timer   = HOLD_LOAD;
                        w_state   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Release on the edge where the count reaches 0 so the
                    // pull lasts exactly HOLD_CYC clocks; the line is blanked.
                    if (r_timer <= TW'(1)) begin
                        w_timer   = '0;
                        w_dq_pull = 1'b0;
                        w_state   = ST_REL;
                    end else begin
                        w_timer = r_timer - TW'(1);
                    end
                end
                ST_REL: begin
                    if (w_dq_s) begin
                        w_shreg  = {1'b1, r_shreg[7:1]};
                        w_bitcnt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_byte_done = 1'b1;
                            w_cur_addr  = r_cur_addr + 16'd1;
                            w_state     = ST_LOAD;
                        end else begin
                            w_state = ST_WAIT;
                        end
                    end
                end
                default: begin
                    w_state   = ST_IDLE;
                    w_dq_pull = 1'b0;
                    w_busy    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_state     <= ST_IDLE;
            r_cur_addr  <= 16'h0000;
            r_shreg     <= 8'hFF;
            r_bitcnt    <= 3'd0;
            r_timer     <= '0;
            r_dq_pull   <= 1'b0;
            r_busy      <= 1'b0;
            r_byte_done <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cur_addr  <= w_cur_addr;
            r_shreg     <= w_shreg;
            r_bitcnt    <= w_bitcnt;
            r_timer     <= w_timer;
            r_dq_pull   <= w_dq_pull;
            r_busy      <= w_busy;
            r_byte_done <= w_byte_done;
        end
    end

    assign o_dq_pull   = r_dq_pull;
    assign o_busy      = r_busy;
    assign o_byte_done = r_byte_done;
    assign o_cur_addr  = r_cur_addr;

endmodule

// File: tb/tb_ds2431_read_streamer.sv
// tb/tb_ds2431_read_streamer.sv - directed scoreboard bench for ds2431_read_streamer
module tb_ds2431_read_streamer;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [7:0]  ta1;
    logic [7:0]  ta2;
    logic        abort;
    logic        master_low;
    logic        glitch;
    logic        dq_line;
    logic        dq_pull;
    logic [7:0]  mem_addr;
    logic [63:0] row_dat;
    logic        busy;
    logic        byte_done;
    logic [15:0] cur_addr;

    logic [7:0]  mem [0:143];
    logic [7:0]  exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int bd_cnt   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Open-drain wired line: low if master, glitch source or DUT pulls.
    assign dq_line = ~(master_low | glitch | dq_pull);

    always_comb begin
        row_dat = '0;
        for (int k = 0; k < 8; k++) begin
            if (({24'd0, mem_addr[7:3], 3'b000} + k) < 144)
                row_dat[8*k +: 8] = mem[{24'd0, mem_addr[7:3], 3'b000} + k];
            else
                row_dat[8*k +: 8] = 8'hFF;
        end
    end

    ds2431_read_streamer dut (
        .i_clk       (clk),
        .i_nRst      (nrst),
        .i_start     (start),
        .i_ta1       (ta1),
        .i_ta2       (ta2),
        .i_abort     (abort),
        .i_dq_in     (dq_line),
        .o_dq_pull   (dq_pull),
        .o_mem_addr  (mem_addr),
        .i_row_dat   (row_dat),
        .o_busy      (busy),
        .o_byte_done (byte_done),
        .o_cur_addr  (cur_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_start(input logic [15:0] a);
        ta2   = a[15:8];
        ta1   = a[7:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
    endtask

    // One 60-clock master read slot: 1 clock low, release, sample at t=15.
    task automatic read_bit(input bit do_glitch, output bit b, output int first_pull, output int pull_cnt);
        first_pull = -1;
        pull_cnt   = 0;
        b          = 1'b1;
        for (int t = 0; t < 60; t++) begin
            master_low = (t == 0);
            glitch     = do_glitch && (t == 10);
            if (dq_pull) begin
                pull_cnt++;
                if (first_pull < 0) first_pull = t;
            end
            if (byte_done) bd_cnt++;
            if (t == 15) b = dq_line;
            @(negedge clk);
        end
        master_low = 1'b0;
        glitch     = 1'b0;
    endtask

    task automatic read_byte(input string tag, input bit do_glitch, output int pulls, output int first_pull0);
        logic [7:0] val;
        logic [7:0] expv;
        bit         b;
        int         fp;
        int         pc;
        pulls       = 0;
        first_pull0 = -1;
        for (int i = 0; i < 8; i++) begin
            read_bit(do_glitch && (i == 0), b, fp, pc);
            val[i] = b;
            pulls += pc;
            if (i == 0) first_pull0 = fp;
        end
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        check(tag, {24'd0, val}, {24'd0, expv});
    endtask

    initial begin
        int pulls;
        int fp0;
        for (int i = 0; i < 144; i++) mem[i] = 8'(i * 37 + 5);
        mem[8'h00] = 8'h00;
        mem[8'h01] = 8'hF0;
        mem[8'h02] = 8'hFF;
        mem[8'h1F] = 8'hFF;
        mem[8'h20] = 8'hED;
        mem[8'h8E] = 8'hAA;
        mem[8'h8F] = 8'h00;

        nrst = 1'b0; start = 1'b0; abort = 1'b0; ta1 = 8'h00; ta2 = 8'h00;
        master_low = 1'b0; glitch = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dq_pull", {31'd0, dq_pull}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_byte_done", {31'd0, byte_done}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_cur_addr", {16'd0, cur_addr}, 32'd0);
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        // Start 0x0000, three bytes
        do_start(16'h0000);
        check("t1_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'hFF);
        bd_cnt = 0;
        read_byte("t1_byte0", 1'b0, pulls, fp0);
        check("t1_first_pull_latency", fp0, 32'd3);
        check("t1_byte0_pull_clks", pulls, 32'd240);
        read_byte("t1_byte1", 1'b0, pulls, fp0);
        check("t1_byte1_pull_clks", pulls, 32'd120);
        check("t1_byte_done_before_b2", bd_cnt, 32'd2);
        read_byte("t1_byte2", 1'b0, pulls, fp0);
        check("t1_byte2_no_pull", pulls, 32'd0);
        check("t1_cur_addr_end", {16'd0, cur_addr}, 32'h0003);
        do_abort();
        check("t1_abort_busy", {31'd0, busy}, 32'd0);

        // Start 0x001F, row crossing, glitch during a '1' HOLD, start while busy
        do_start(16'h001F);
        check("t2_mem_addr0", {24'd0, mem_addr}, 32'h1F);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hED);
        read_byte("t2_byte0_glitch", 1'b1, pulls, fp0);
        check("t2_byte0_no_pull", pulls, 32'd0);
        do_start(16'h0000);
        check("t2_start_busy_ignored", {16'd0, cur_addr}, 32'h0020);
        check("t2_mem_addr1", {24'd0, mem_addr}, 32'h20);
        read_byte("t2_byte1", 1'b0, pulls, fp0);
        do_abort();

        // Start 0x008E, option row then past the end
        do_start(16'h008E);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        read_byte("t3_byte0", 1'b0, pulls, fp0);
        read_byte("t3_byte1", 1'b0, pulls, fp0);
        read_byte("t3_byte2", 1'b0, pulls, fp0);
        check("t3_byte2_no_pull", pulls, 32'd0);
        read_byte("t3_byte3", 1'b0, pulls, fp0);
        check("t3_byte3_no_pull", pulls, 32'd0);
        check("t3_cur_addr_end", {16'd0, cur_addr}, 32'h0092);
        do_abort();

        // Start with ta2 != 0
        do_start(16'h0100);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        read_byte("t4_byte0", 1'b0, pulls, fp0);
        check("t4_byte0_no_pull", pulls, 32'd0);
        read_byte("t4_byte1", 1'b0, pulls, fp0);
        check("t4_byte1_no_pull", pulls, 32'd0);
        do_abort();

        // Abort during HOLD of a '0' bit
        do_start(16'h0000);
        master_low = 1'b1;
        @(negedge clk);
        master_low = 1'b0;
        repeat (9) @(negedge clk);
        check("t5_pull_in_hold", {31'd0, dq_pull}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_pull", {31'd0, dq_pull}, 32'd0);
        check("t5_abort_busy", {31'd0, busy}, 32'd0);
        repeat (60) @(negedge clk);
        check("t5_idle_no_pull", {31'd0, dq_pull}, 32'd0);
        do_start(16'h0001);
        exp_q.push_back(8'hF0);
        read_byte("t5_restart_byte", 1'b0, pulls, fp0);
        check("t5_scoreboard_empty", exp_q.size(), 32'd0);
        do_abort();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
